// File: rtl/alu_cmd_issuer.sv
// Single-in-flight command issuer driving an ALU with the A-op or B-op opcode set; IDLE -> DRIVE -> RESP.
// Optional DRIVE-state timeout is enabled by defining ALU_CMD_ISSUER_TIMEOUT_EN.
module alu_cmd_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic signed [4:0] cmd_a,
  input  logic signed [4:0] cmd_b,
  input  logic              cmd_sel,
  input  logic [2:0]        cmd_op,
  output logic              ALU_en,
  output logic              a_en,
  output logic              b_en,
  output logic signed [4:0] A,
  output logic signed [4:0] B,
  output logic [2:0]        a_op,
  output logic [1:0]        b_op,
  input  logic              C_en,
  input  logic signed [5:0] C,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic signed [5:0] rsp_c,
  output logic              rsp_err,
  output logic [7:0]        done_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t state;
  logic   drive_done;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_cmd_issuer: TIMEOUT_CYCLES must be in 2..255");
  end

  // rst_n is active-high here; the issuer only offers readiness once reset is released.
  assign cmd_ready = (state == IDLE) && !rst_n;

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  assign tmo_hit    = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign drive_done = C_en || tmo_hit;
`else
  assign drive_done = C_en;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      ALU_en    <= 1'b0;
      a_en      <= 1'b0;
      b_en      <= 1'b0;
      A         <= '0;
      B         <= '0;
      a_op      <= '0;
      b_op      <= '0;
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      done_cnt  <= '0;
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= DRIVE;
            ALU_en <= 1'b1;
            a_en   <= !cmd_sel;
            b_en   <= cmd_sel;
            A      <= cmd_a;
            B      <= cmd_b;
            a_op   <= cmd_sel ? 3'b000 : cmd_op;
            b_op   <= cmd_sel ? cmd_op[1:0] : 2'b00;
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        DRIVE: begin
          if (drive_done) begin
            // A real result beats a coincident timeout.
            state     <= RESP;
            ALU_en    <= 1'b0;
            a_en      <= 1'b0;
            b_en      <= 1'b0;
            A         <= '0;
            B         <= '0;
            a_op      <= '0;
            b_op      <= '0;
            rsp_valid <= 1'b1;
            rsp_c     <= C_en ? C : 6'sd0;
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
            rsp_err   <= !C_en;
`endif
          end
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            if (done_cnt != 8'hFF) begin
              done_cnt <= done_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed table-driven bench for alu_cmd_issuer; timeout sequences apply when ALU_CMD_ISSUER_TIMEOUT_EN is defined.
module tb_alu_cmd_issuer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [4:0] cmd_a;
  logic signed [4:0] cmd_b;
  logic              cmd_sel;
  logic [2:0]        cmd_op;
  logic              ALU_en, a_en, b_en;
  logic signed [4:0] A, B;
  logic [2:0]        a_op;
  logic [1:0]        b_op;
  logic              C_en;
  logic signed [5:0] C;
  logic              rsp_valid;
  logic              rsp_ready;
  logic signed [5:0] rsp_c;
  logic              rsp_err;
  logic [7:0]        done_cnt;

  int errors = 0;
  int checks = 0;
  int exp_done = 0;

  alu_cmd_issuer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_op(cmd_op),
    .ALU_en(ALU_en), .a_en(a_en), .b_en(b_en), .A(A), .B(B),
    .a_op(a_op), .b_op(b_op), .C_en(C_en), .C(C),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_err(rsp_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [4:0] a;
    logic signed [4:0] b;
    logic              sel;
    logic [2:0]        op;
    logic signed [5:0] c;
    int                wait_cyc;
    logic              ea_en;
    logic              eb_en;
    logic [2:0]        ea_op;
    logic [1:0]        eb_op;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bump_done;
    exp_done = (exp_done == 255) ? 255 : exp_done + 1;
  endtask

  task automatic issue(input logic signed [4:0] a, input logic signed [4:0] b,
                       input logic sel, input logic [2:0] op);
    chk("ready_idle", int'(cmd_ready), 1);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_op = op; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.a, v.b, v.sel, v.op);
    for (int i = 0; i <= v.wait_cyc; i++) begin
      chk("alu_en", int'(ALU_en), 1);
      chk("a_en", int'(a_en), int'(v.ea_en));
      chk("b_en", int'(b_en), int'(v.eb_en));
      chk("A", int'(A), int'(v.a));
      chk("B", int'(B), int'(v.b));
      chk("a_op", int'(a_op), int'(v.ea_op));
      chk("b_op", int'(b_op), int'(v.eb_op));
      chk("ready_drive", int'(cmd_ready), 0);
      chk("valid_drive", int'(rsp_valid), 0);
      if (i == v.wait_cyc) begin
        C_en = 1'b1; C = v.c;
      end
      tick();
    end
    C_en = 1'b0; C = 6'sd0;
    chk("rsp_valid", int'(rsp_valid), 1);
    chk("rsp_c", int'(rsp_c), int'(v.c));
    chk("rsp_err", int'(rsp_err), 0);
    chk("alu_en_resp", int'(ALU_en), 0);
    chk("a_en_resp", int'(a_en) + int'(b_en), 0);
    chk("ready_resp", int'(cmd_ready), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    bump_done();
    chk("valid_after", int'(rsp_valid), 0);
    chk("ready_after", int'(cmd_ready), 1);
    chk("done_cnt", int'(done_cnt), exp_done);
  endtask

  initial begin
    vecs[0] = '{a:5,   b:-3, sel:0, op:2, c:2,   wait_cyc:0, ea_en:1, eb_en:0, ea_op:2, eb_op:0};
    vecs[1] = '{a:-16, b:15, sel:1, op:7, c:-32, wait_cyc:2, ea_en:0, eb_en:1, ea_op:0, eb_op:3};
    vecs[2] = '{a:0,   b:0,  sel:0, op:7, c:31,  wait_cyc:1, ea_en:1, eb_en:0, ea_op:7, eb_op:0};
    vecs[3] = '{a:-1,  b:-1, sel:1, op:4, c:-1,  wait_cyc:0, ea_en:0, eb_en:1, ea_op:0, eb_op:0};
    vecs[4] = '{a:7,   b:-8, sel:1, op:1, c:0,   wait_cyc:0, ea_en:0, eb_en:1, ea_op:0, eb_op:1};

    rst_n = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = 1'b0; cmd_op = '0;
    C_en = 1'b0; C = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_alu_en", int'(ALU_en), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_done", int'(done_cnt), 0);
    rst_n = 1'b0;
    #1;
    chk("ready_release", int'(cmd_ready), 1);
    @(negedge clk);

    // Stray C_en in IDLE is ignored
    C_en = 1'b1; C = 6'sd13;
    tick();
    C_en = 1'b0; C = '0;
    chk("idle_cen_valid", int'(rsp_valid), 0);
    chk("idle_cen_rsp_c", int'(rsp_c), 0);
    chk("idle_cen_ready", int'(cmd_ready), 1);
    chk("idle_cen_alu", int'(ALU_en), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Response backpressure for 5 cycles
    issue(5'sd3, 5'sd4, 1'b0, 3'd1);
    C_en = 1'b1; C = -6'sd20;
    tick();
    C_en = 1'b0; C = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_c", int'(rsp_c), -20);
      chk("bp_ready", int'(cmd_ready), 0);
      chk("bp_done", int'(done_cnt), exp_done);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    bump_done();
    chk("bp_done_after", int'(done_cnt), exp_done);
    chk("bp_valid_after", int'(rsp_valid), 0);

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
    issue(5'sd1, 5'sd2, 1'b0, 3'd3);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_alu_en", int'(ALU_en), 1);
      chk("tmo_valid_drive", int'(rsp_valid), 0);
      tick();
    end
    chk("tmo_valid", int'(rsp_valid), 1);
    chk("tmo_err", int'(rsp_err), 1);
    chk("tmo_rsp_c", int'(rsp_c), 0);
    chk("tmo_alu_off", int'(ALU_en), 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    bump_done();
    chk("tmo_done", int'(done_cnt), exp_done);
    issue(5'sd1, 5'sd2, 1'b1, 3'd2);
    tick(); tick(); tick();
    chk("tmo_race_alu", int'(ALU_en), 1);
    C_en = 1'b1; C = -6'sd7;
    tick();
    C_en = 1'b0; C = '0;
    chk("race_valid", int'(rsp_valid), 1);
    chk("race_err", int'(rsp_err), 0);
    chk("race_rsp_c", int'(rsp_c), -7);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    bump_done();
    chk("race_done", int'(done_cnt), exp_done);
`else
    issue(5'sd1, 5'sd2, 1'b0, 3'd3);
    for (int i = 0; i < 20; i++) tick();
    chk("wait_alu_en", int'(ALU_en), 1);
    chk("wait_valid", int'(rsp_valid), 0);
    C_en = 1'b1; C = 6'sd9;
    tick();
    C_en = 1'b0; C = '0;
    chk("wait_rsp_c", int'(rsp_c), 9);
    chk("wait_err", int'(rsp_err), 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    bump_done();
    chk("wait_done", int'(done_cnt), exp_done);
`endif

    // Reset asserted mid-DRIVE
    issue(5'sd6, 5'sd6, 1'b1, 3'd2);
    chk("mid_alu_en", int'(ALU_en), 1);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_alu", int'(ALU_en), 0);
    chk("mid_rst_b_en", int'(b_en), 0);
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_ready", int'(cmd_ready), 0);
    chk("mid_rst_done", int'(done_cnt), 0);
    exp_done = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rel_ready", int'(cmd_ready), 1);
    @(negedge clk);
    C_en = 1'b1; C = 6'sd5;
    tick();
    C_en = 1'b0; C = '0;
    chk("mid_no_rsp", int'(rsp_valid), 0);
    chk("mid_alu_idle", int'(ALU_en), 0);

    // done_cnt saturation
    for (int i = 0; i < 258; i++) run_vec(vecs[0]);
    chk("done_sat", int'(done_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
